// File: rtl/time_entry.sv
// Time/alarm entry: three-button editor for an HH:MM value with load strobes.
// Ports: clk, reset (async, active-high); btn_mode/btn_inc/btn_ok level inputs;
//   target_alarm selects the load target at edit start; H_in1/H_in0/M_in1/M_in0
//   BCD working value; LD_time/LD_alarm load strobes; edit_field state; busy.
module time_entry #(
    parameter int LD_HOLD = 10,
    parameter int TIMEOUT = 300
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_ok,
    input  logic       target_alarm,
    output logic [1:0] H_in1,
    output logic [3:0] H_in0,
    output logic [3:0] M_in1,
    output logic [3:0] M_in0,
    output logic       LD_time,
    output logic       LD_alarm,
    output logic [1:0] edit_field,
    output logic       busy
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int LW = $clog2(LD_HOLD + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        EDIT_HR  = 2'b01,
        EDIT_MIN = 2'b10,
        LOAD     = 2'b11
    } state_t;

    state_t          state;
    logic            mode_prev;
    logic            inc_prev;
    logic            ok_prev;
    logic            target;
    logic [TW-1:0]   to_cnt;
    logic [LW-1:0]   ld_cnt;

    logic mode_e;
    logic inc_e;
    logic ok_e;

    assign mode_e = btn_mode & ~mode_prev;
    assign inc_e  = btn_inc & ~inc_prev;
    assign ok_e   = btn_ok & ~ok_prev;

    // The state register doubles as the field indicator.
    assign edit_field = state;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            mode_prev <= 1'b0;
            inc_prev  <= 1'b0;
            ok_prev   <= 1'b0;
            target    <= 1'b0;
            to_cnt    <= '0;
            ld_cnt    <= '0;
            H_in1     <= 2'd0;
            H_in0     <= 4'd0;
            M_in1     <= 4'd0;
            M_in0     <= 4'd0;
            LD_time   <= 1'b0;
            LD_alarm  <= 1'b0;
        end else begin
            mode_prev <= btn_mode;
            inc_prev  <= btn_inc;
            ok_prev   <= btn_ok;
            unique case (state)
                IDLE: begin
                    if (mode_e) begin
                        state  <= EDIT_HR;
                        target <= target_alarm;
                        to_cnt <= '0;
                    end
                end
                EDIT_HR, EDIT_MIN: begin
                    // ok beats mode beats inc; lower edges are dropped.
                    if (ok_e) begin
                        state    <= LOAD;
                        ld_cnt   <= '0;
                        to_cnt   <= '0;
                        LD_time  <= ~target;
                        LD_alarm <= target;
                    end else if (mode_e) begin
                        state  <= (state == EDIT_HR) ? EDIT_MIN : EDIT_HR;
                        to_cnt <= '0;
                    end else if (inc_e) begin
                        to_cnt <= '0;
                        if (state == EDIT_HR) begin
                            if (H_in1 == 2'd2 && H_in0 == 4'd3) begin
                                H_in1 <= 2'd0;
                                H_in0 <= 4'd0;
                            end else if (H_in0 == 4'd9) begin
                                H_in1 <= H_in1 + 2'd1;
                                H_in0 <= 4'd0;
                            end else begin
                                H_in0 <= H_in0 + 4'd1;
                            end
                        end else begin
                            if (M_in0 == 4'd9) begin
                                M_in0 <= 4'd0;
                                M_in1 <= (M_in1 == 4'd5) ? 4'd0 : M_in1 + 4'd1;
                            end else begin
                                M_in0 <= M_in0 + 4'd1;
                            end
                        end
                    end else if (to_cnt == TW'(TIMEOUT - 1)) begin
                        // Abandoned edit: keep the value, no strobe.
                        state  <= IDLE;
                        to_cnt <= '0;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                LOAD: begin
                    if (ld_cnt == LW'(LD_HOLD - 1)) begin
                        state    <= IDLE;
                        ld_cnt   <= '0;
                        LD_time  <= 1'b0;
                        LD_alarm <= 1'b0;
                    end else begin
                        ld_cnt <= ld_cnt + LW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_time_entry.sv
// Testbench for time_entry: directed button sequences with a scoreboard
// of output snapshots and a strobe-pulse monitor.
module tb_time_entry;

    localparam int LD_HOLD = 10;
    localparam int TIMEOUT = 300;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_mode;
    logic       btn_inc;
    logic       btn_ok;
    logic       target_alarm;
    logic [1:0] H_in1;
    logic [3:0] H_in0;
    logic [3:0] M_in1;
    logic [3:0] M_in0;
    logic       LD_time;
    logic       LD_alarm;
    logic [1:0] edit_field;
    logic       busy;

    time_entry #(.LD_HOLD(LD_HOLD), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_ok(btn_ok),
        .target_alarm(target_alarm),
        .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
        .LD_time(LD_time), .LD_alarm(LD_alarm),
        .edit_field(edit_field), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        string       name;
        logic [18:0] val;
    } snap_t;

    typedef struct {
        string name;
        bit    alarm;
        int    len;
    } pulse_t;

    snap_t  sq[$];
    pulse_t pq[$];
    int     cyc = 0;
    int     tests = 0;
    int     fails = 0;
    int     lt_run = 0;
    int     la_run = 0;
    int     ovl = 0;

    always @(posedge clk) cyc++;

    // {busy, edit_field, LD_time, LD_alarm, H1, H0, M1, M0}
    function automatic logic [18:0] mk(input int ef, input int lt, input int la,
                                       input int hh, input int mm);
        logic [18:0] v;
        v = {(ef != 0), 2'(ef), 1'(lt), 1'(la),
             2'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10)};
        return v;
    endfunction

    function automatic logic [18:0] obs();
        return {busy, edit_field, LD_time, LD_alarm, H_in1, H_in0, M_in1, M_in0};
    endfunction

    task automatic expect_now(input string name, input logic [18:0] v);
        snap_t s;
        s.cyc = cyc; s.name = name; s.val = v;
        sq.push_back(s);
    endtask

    task automatic expect_pulse(input string name, input bit alarm, input int len);
        pulse_t p;
        p.name = name; p.alarm = alarm; p.len = len;
        pq.push_back(p);
    endtask

    task automatic end_pulse(input bit alarm, input int len);
        pulse_t p;
        tests++;
        if (pq.size() == 0) begin
            fails++;
            $display("FAIL unexpected_pulse: alarm=%0d len=%0d, none expected", alarm, len);
        end else begin
            p = pq.pop_front();
            if (p.alarm != alarm || p.len != len || ovl != 0) begin
                fails++;
                $display("FAIL %s: got alarm=%0d len=%0d overlap=%0d, want alarm=%0d len=%0d overlap=0",
                         p.name, alarm, len, ovl, p.alarm, p.len);
            end
        end
        ovl = 0;
    endtask

    // Monitor: snapshots due this cycle, then strobe pulse tracking.
    always @(negedge clk) begin
        snap_t s;
        logic [18:0] o;
        o = obs();
        while (sq.size() > 0 && sq[0].cyc <= cyc) begin
            s = sq.pop_front();
            tests++;
            if (s.cyc != cyc || o !== s.val) begin
                fails++;
                $display("FAIL %s: got %h want %h (cycle %0d, due %0d)",
                         s.name, o, s.val, cyc, s.cyc);
            end
        end
        if (LD_time && LD_alarm) ovl++;
        if (LD_time) lt_run++;
        else if (lt_run > 0) begin
            end_pulse(1'b0, lt_run);
            lt_run = 0;
        end
        if (LD_alarm) la_run++;
        else if (la_run > 0) begin
            end_pulse(1'b1, la_run);
            la_run = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input bit m, input bit i, input bit o);
        btn_mode = m; btn_inc = i; btn_ok = o;
        tick();
        btn_mode = 1'b0; btn_inc = 1'b0; btn_ok = 1'b0;
        tick();
    endtask

    task automatic wait_idle(input string name, input int max);
        for (int i = 0; i < max; i++) begin
            if (!busy) return;
            tick();
        end
        tests++;
        fails++;
        $display("FAIL %s: busy=%0d after %0d cycles, want 0", name, busy, max);
    endtask

    initial begin
        reset = 1'b1;
        btn_mode = 1'b0; btn_inc = 1'b0; btn_ok = 1'b0;
        target_alarm = 1'b0;
        tick(); tick();
        expect_now("reset_state", mk(0, 0, 0, 0, 0));
        reset = 1'b0;
        tick();

        // Basic entry: 03:02 into the time register.
        press(1, 0, 0);
        expect_now("enter_hr", mk(1, 0, 0, 0, 0));
        repeat (3) press(0, 1, 0);
        expect_now("hr_03", mk(1, 0, 0, 3, 0));
        press(1, 0, 0);
        repeat (2) press(0, 1, 0);
        expect_now("min_02", mk(2, 0, 0, 3, 2));
        expect_pulse("ld_time_basic", 1'b0, LD_HOLD);
        press(0, 0, 1);
        expect_now("load_basic", mk(3, 1, 0, 3, 2));
        wait_idle("idle_after_basic", 30);
        expect_now("idle_basic", mk(0, 0, 0, 3, 2));

        // inc and ok are ignored while idle.
        press(0, 1, 0);
        press(0, 0, 1);
        expect_now("idle_ignore", mk(0, 0, 0, 3, 2));

        // Hour carries and wrap, starting from the retained value.
        press(1, 0, 0);
        expect_now("resume", mk(1, 0, 0, 3, 2));
        repeat (7) press(0, 1, 0);
        expect_now("h09_10", mk(1, 0, 0, 10, 2));
        repeat (10) press(0, 1, 0);
        expect_now("h19_20", mk(1, 0, 0, 20, 2));
        repeat (3) press(0, 1, 0);
        expect_now("h23", mk(1, 0, 0, 23, 2));
        press(0, 1, 0);
        expect_now("h_wrap", mk(1, 0, 0, 0, 2));
        press(0, 1, 0);

        // Minute carries and wrap, hours untouched.
        press(1, 0, 0);
        expect_now("to_min", mk(2, 0, 0, 1, 2));
        repeat (8) press(0, 1, 0);
        expect_now("m09_10", mk(2, 0, 0, 1, 10));
        repeat (49) press(0, 1, 0);
        expect_now("m59", mk(2, 0, 0, 1, 59));
        press(0, 1, 0);
        expect_now("m_wrap", mk(2, 0, 0, 1, 0));

        // Priority: mode over inc, then ok over inc.
        press(1, 1, 0);
        expect_now("mode_inc_hr", mk(1, 0, 0, 1, 0));
        press(1, 1, 0);
        expect_now("mode_inc_min", mk(2, 0, 0, 1, 0));
        press(0, 1, 0);
        expect_now("m01", mk(2, 0, 0, 1, 1));
        expect_pulse("ld_time_ok_inc", 1'b0, LD_HOLD);
        btn_ok = 1'b1; btn_inc = 1'b1;
        tick();
        expect_now("ok_inc", mk(3, 1, 0, 1, 1));
        btn_ok = 1'b0; btn_inc = 1'b0;
        tick();
        press(0, 1, 0);
        expect_now("load_ignore", mk(3, 1, 0, 1, 1));
        wait_idle("idle_after_ok_inc", 30);
        expect_now("idle_ok_inc", mk(0, 0, 0, 1, 1));

        // Alarm target latched at edit start only.
        target_alarm = 1'b1;
        press(1, 0, 0);
        target_alarm = 1'b0;
        expect_now("alarm_edit", mk(1, 0, 0, 1, 1));
        press(0, 1, 0);
        expect_pulse("ld_alarm", 1'b1, LD_HOLD);
        press(0, 0, 1);
        expect_now("alarm_load", mk(3, 0, 1, 2, 1));
        wait_idle("idle_after_alarm", 30);
        expect_now("idle_alarm", mk(0, 0, 0, 2, 1));

        // Timeout: counter restarts on the inc edge.
        press(1, 0, 0);
        press(0, 1, 0);
        repeat (TIMEOUT - 2) tick();
        expect_now("pre_timeout", mk(1, 0, 0, 3, 1));
        tick();
        expect_now("timeout", mk(0, 0, 0, 3, 1));
        press(1, 0, 0);
        expect_now("resume_after_to", mk(1, 0, 0, 3, 1));

        // Reset in cycle 4 of LOAD.
        expect_pulse("ld_time_reset", 1'b0, 3);
        btn_ok = 1'b1;
        tick();
        btn_ok = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1;
        expect_now("reset_in_load", mk(0, 0, 0, 0, 0));

        // Mode held through reset release: one edge only.
        btn_mode = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        expect_now("held_through_reset", mk(1, 0, 0, 0, 0));
        tick(); tick();
        expect_now("held_no_edge", mk(1, 0, 0, 0, 0));
        btn_mode = 1'b0;
        repeat (3) tick();

        tests++;
        if (sq.size() != 0 || pq.size() != 0) begin
            fails++;
            $display("FAIL leftover: got %0d snapshots %0d pulses pending, want 0 0",
                     sq.size(), pq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
